// File: rtl/mem_arb2p_if.sv
// One requester port of the two-port RAM arbiter: request, access type, address, data, ack pulse, read data.
interface mem_arb2p_if #(
   parameter int ADDR_W = 6,
   parameter int DATA_W = 32
) ();
   logic              req;
   logic              we;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic              ack;
   logic [DATA_W-1:0] rdata;

   modport master (output req, we, addr, wdata, input ack, rdata);
   modport slave  (input req, we, addr, wdata, output ack, rdata);
endinterface

// File: rtl/mem_arb2p.sv
// Two-port arbiter/sequencer for a 1-cycle-latency sync RAM; MEM_ARB_FIXED_PRIO_EN makes port 0 win every tie.
// Write acked 2 cycles after the grant cycle, read 3; the losing port simply holds req until served.
module mem_arb2p #(
   parameter int ADDR_W = 6,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   mem_arb2p_if.slave        p0_if,
   mem_arb2p_if.slave        p1_if,
   output logic              ram_we_o,
   output logic [ADDR_W-1:0] ram_addr_o,
   output logic [DATA_W-1:0] ram_din_o,
   input  logic [DATA_W-1:0] ram_dout_i,
   output logic              busy_o
);

   typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, ACK} state_t;

   state_t            state_q, state_d;
   logic              owner_q, owner_d;
   logic              ram_we_q, ram_we_d;
   logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
   logic [DATA_W-1:0] ram_din_q, ram_din_d;
   logic              ack0_q, ack0_d;
   logic              ack1_q, ack1_d;
   logic [DATA_W-1:0] rdata0_q, rdata0_d;
   logic [DATA_W-1:0] rdata1_q, rdata1_d;
   logic              busy_q, busy_d;
   logic              gnt_vld;
   logic              gnt_port;
`ifndef MEM_ARB_FIXED_PRIO_EN
   logic              last_q, last_d;
`endif

   always_comb begin
      gnt_vld = p0_if.req | p1_if.req;
      if (p0_if.req && p1_if.req) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
         gnt_port = 1'b0;
`else
         gnt_port = ~last_q;
`endif
      end else begin
         gnt_port = p1_if.req;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         owner_q    <= 1'b0;
         ram_we_q   <= 1'b0;
         ram_addr_q <= '0;
         ram_din_q  <= '0;
         ack0_q     <= 1'b0;
         ack1_q     <= 1'b0;
         rdata0_q   <= '0;
         rdata1_q   <= '0;
         busy_q     <= 1'b0;
`ifndef MEM_ARB_FIXED_PRIO_EN
         last_q     <= 1'b1;
`endif
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         ram_we_q   <= ram_we_d;
         ram_addr_q <= ram_addr_d;
         ram_din_q  <= ram_din_d;
         ack0_q     <= ack0_d;
         ack1_q     <= ack1_d;
         rdata0_q   <= rdata0_d;
         rdata1_q   <= rdata1_d;
         busy_q     <= busy_d;
`ifndef MEM_ARB_FIXED_PRIO_EN
         last_q     <= last_d;
`endif
      end
   end

   // ram_we_q doubles as the access type while in ISSUE.
   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
`ifndef MEM_ARB_FIXED_PRIO_EN
      last_d  = last_q;
`endif
      case (state_q)
         IDLE: begin
            if (gnt_vld) begin
               state_d = ISSUE;
               owner_d = gnt_port;
`ifndef MEM_ARB_FIXED_PRIO_EN
               last_d  = gnt_port;
`endif
            end
         end
         ISSUE:   state_d = ram_we_q ? ACK : CAPTURE;
         CAPTURE: state_d = ACK;
         ACK:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      ram_we_d   = 1'b0;
      ram_addr_d = ram_addr_q;
      ram_din_d  = ram_din_q;
      if (state_q == IDLE && gnt_vld) begin
         ram_we_d   = gnt_port ? p1_if.we    : p0_if.we;
         ram_addr_d = gnt_port ? p1_if.addr  : p0_if.addr;
         ram_din_d  = gnt_port ? p1_if.wdata : p0_if.wdata;
      end
      ack0_d   = (state_d == ACK) && !owner_q;
      ack1_d   = (state_d == ACK) &&  owner_q;
      rdata0_d = (state_q == CAPTURE && !owner_q) ? ram_dout_i : rdata0_q;
      rdata1_d = (state_q == CAPTURE &&  owner_q) ? ram_dout_i : rdata1_q;
      busy_d   = (state_d != IDLE);
   end

   assign ram_we_o    = ram_we_q;
   assign ram_addr_o  = ram_addr_q;
   assign ram_din_o   = ram_din_q;
   assign busy_o      = busy_q;
   assign p0_if.ack   = ack0_q;
   assign p1_if.ack   = ack1_q;
   assign p0_if.rdata = rdata0_q;
   assign p1_if.rdata = rdata1_q;

endmodule

// File: tb/tb_mem_arb2p.sv
// Bench for mem_arb2p: hand-built vector table, randomized pairs against a transaction-level model, corner sequences.
`timescale 1ns/1ps
module tb_mem_arb2p;
   localparam int AW = 6;
   localparam int DW = 32;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   mem_arb2p_if #(.ADDR_W(AW), .DATA_W(DW)) p0_if ();
   mem_arb2p_if #(.ADDR_W(AW), .DATA_W(DW)) p1_if ();

   logic          ram_we;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_din;
   logic [DW-1:0] ram_dout;
   logic          busy;

   mem_arb2p #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk        (clk),
      .rst        (rst),
      .p0_if      (p0_if),
      .p1_if      (p1_if),
      .ram_we_o   (ram_we),
      .ram_addr_o (ram_addr),
      .ram_din_o  (ram_din),
      .ram_dout_i (ram_dout),
      .busy_o     (busy)
   );

   // Behavioural RAM_B: registered read, write on we.
   logic [DW-1:0] ram_mem [64] = '{default: '0};
   always @(posedge clk) begin
      if (ram_we) ram_mem[ram_addr] <= ram_din;
      ram_dout <= ram_mem[ram_addr];
   end

   int n_chk = 0;
   int n_fail = 0;

   // Reference model state: memory contents, each port's read data, last granted port.
   logic [DW-1:0] m_mem [64];
   logic [DW-1:0] m_rd [2];
   int            m_last;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   function automatic int tie_winner();
`ifdef MEM_ARB_FIXED_PRIO_EN
      return 0;
`else
      return 1 - m_last;
`endif
   endfunction

   // Serve the enabled ports in arbitration order; each access takes 2 (write) or 3 (read)
   // cycles to ack, and the next grant happens in the IDLE cycle right after an ack.
   task automatic model_run(input logic en0, we0, input logic [5:0] a0, input logic [31:0] d0,
                            input logic en1, we1, input logic [5:0] a1, input logic [31:0] d1,
                            output int e0, output int e1, output int nwr);
      logic en [2]; logic we [2]; logic [5:0] ad [2]; logic [31:0] dt [2];
      int ack [2]; int first; int p; int t;
      en[0] = en0; we[0] = we0; ad[0] = a0; dt[0] = d0;
      en[1] = en1; we[1] = we1; ad[1] = a1; dt[1] = d1;
      ack[0] = -1; ack[1] = -1; nwr = 0; t = 0;
      first = (en0 && en1) ? tie_winner() : (en1 ? 1 : 0);
      for (int k = 0; k < 2; k++) begin
         p = (k == 0) ? first : 1 - first;
         if (en[p]) begin
            ack[p] = t + (we[p] ? 2 : 3);
            if (we[p]) begin m_mem[ad[p]] = dt[p]; nwr++; end
            else m_rd[p] = m_mem[ad[p]];
            t = ack[p] + 1;
            m_last = p;
         end
      end
      e0 = ack[0]; e1 = ack[1];
   endtask

   task automatic run_set(input logic en0, we0, input logic [5:0] a0, input logic [31:0] d0,
                          input logic en1, we1, input logic [5:0] a1, input logic [31:0] d1,
                          output int ack0_cyc, output int ack1_cyc, output int we_cyc,
                          output logic [5:0] we_a, output logic [31:0] we_d,
                          output int we_cnt, output int overlap);
      logic s0, s1;
      ack0_cyc = -1; ack1_cyc = -1; we_cyc = -1; we_cnt = 0; overlap = 0;
      we_a = '0; we_d = '0;
      @(posedge clk); #1;
      p0_if.req = en0; p0_if.we = we0; p0_if.addr = a0; p0_if.wdata = d0;
      p1_if.req = en1; p1_if.we = we1; p1_if.addr = a1; p1_if.wdata = d1;
      for (int c = 0; c < 20 && ((en0 && ack0_cyc < 0) || (en1 && ack1_cyc < 0)); c++) begin
         @(negedge clk);
         if (ram_we) begin
            we_cnt++;
            if (we_cyc < 0) begin we_cyc = c; we_a = ram_addr; we_d = ram_din; end
         end
         s0 = p0_if.ack; s1 = p1_if.ack;
         if (s0 && s1) overlap++;
         if (s0 && ack0_cyc < 0) ack0_cyc = c;
         if (s1 && ack1_cyc < 0) ack1_cyc = c;
         @(posedge clk); #1;
         if (s0) p0_if.req = 1'b0;
         if (s1) p1_if.req = 1'b0;
      end
      p0_if.req = 1'b0;
      p1_if.req = 1'b0;
   endtask

   typedef struct {
      logic en0; logic we0; logic [5:0] a0; logic [31:0] d0;
      logic en1; logic we1; logic [5:0] a1; logic [31:0] d1;
      int e_ack0; int e_ack1; int e_wec; logic [5:0] e_wa; logic [31:0] e_wd;
      logic [31:0] e_rd0; logic [31:0] e_rd1;
   } vec_t;

   vec_t tbl [8];

   task automatic apply_and_check(input string tag, input vec_t v, input logic use_model);
      int a0c, a1c, wec, wcnt, ovl, e0, e1, nwr;
      logic [5:0] wa; logic [31:0] wd;
      model_run(v.en0, v.we0, v.a0, v.d0, v.en1, v.we1, v.a1, v.d1, e0, e1, nwr);
      run_set(v.en0, v.we0, v.a0, v.d0, v.en1, v.we1, v.a1, v.d1, a0c, a1c, wec, wa, wd, wcnt, ovl);
      @(negedge clk);
      if (use_model) begin
         chk({tag, " ack0 cycle"}, a0c, e0);
         chk({tag, " ack1 cycle"}, a1c, e1);
         chk({tag, " rdata0"}, p0_if.rdata, m_rd[0]);
         chk({tag, " rdata1"}, p1_if.rdata, m_rd[1]);
      end else begin
         chk({tag, " ack0 cycle"}, a0c, v.e_ack0);
         chk({tag, " ack1 cycle"}, a1c, v.e_ack1);
         chk({tag, " rdata0"}, p0_if.rdata, v.e_rd0);
         chk({tag, " rdata1"}, p1_if.rdata, v.e_rd1);
         chk({tag, " first we cycle"}, wec, v.e_wec);
         if (v.e_wec >= 0) begin
            chk({tag, " we addr"}, {26'd0, wa}, {26'd0, v.e_wa});
            chk({tag, " we data"}, wd, v.e_wd);
         end
      end
      chk({tag, " we pulses"}, wcnt, nwr);
      chk({tag, " ack overlap"}, ovl, 0);
   endtask

   task automatic alt_seq();
      int order [$]; int exp_first; int ovl, busy_bad, rd_bad, seq_bad;
      logic s0, s1, prev_ack, exp_busy;
      logic [5:0] pa0, pa1;
      ovl = 0; busy_bad = 0; rd_bad = 0; seq_bad = 0; prev_ack = 1'b0;
      exp_first = tie_winner();
      @(posedge clk); #1;
      pa0 = 6'($urandom_range(16, 31)); pa1 = 6'($urandom_range(16, 31));
      p0_if.req = 1'b1; p0_if.we = 1'b0; p0_if.addr = pa0;
      p1_if.req = 1'b1; p1_if.we = 1'b0; p1_if.addr = pa1;
      for (int c = 0; c < 80 && order.size() < 8; c++) begin
         @(negedge clk);
         s0 = p0_if.ack; s1 = p1_if.ack;
         if (s0 && s1) ovl++;
         exp_busy = !(c == 0 || prev_ack);
         if (busy !== exp_busy) busy_bad++;
         if (s0) begin
            order.push_back(0);
            if (p0_if.rdata !== m_mem[pa0]) rd_bad++;
            m_rd[0] = m_mem[pa0]; m_last = 0;
         end
         if (s1) begin
            order.push_back(1);
            if (p1_if.rdata !== m_mem[pa1]) rd_bad++;
            m_rd[1] = m_mem[pa1]; m_last = 1;
         end
         prev_ack = s0 | s1;
         @(posedge clk); #1;
         if (order.size() >= 8) begin
            p0_if.req = 1'b0; p1_if.req = 1'b0;
         end else begin
            if (s0) p0_if.req = 1'b0;
            else if (!p0_if.req) begin pa0 = 6'($urandom_range(16, 31)); p0_if.addr = pa0; p0_if.req = 1'b1; end
            if (s1) p1_if.req = 1'b0;
            else if (!p1_if.req) begin pa1 = 6'($urandom_range(16, 31)); p1_if.addr = pa1; p1_if.req = 1'b1; end
         end
      end
      p0_if.req = 1'b0; p1_if.req = 1'b0;
      foreach (order[i]) if (order[i] != ((exp_first + i) % 2)) seq_bad++;
      chk("alt ack count", order.size(), 8);
      chk("alt grant order", seq_bad, 0);
      chk("alt ack overlap", ovl, 0);
      chk("alt busy vs idle", busy_bad, 0);
      chk("alt rdata", rd_bad, 0);
      @(negedge clk);
   endtask

   initial begin
      vec_t v; int acks, busy_hi;
      p0_if.req = 1'b0; p0_if.we = 1'b0; p0_if.addr = '0; p0_if.wdata = '0;
      p1_if.req = 1'b0; p1_if.we = 1'b0; p1_if.addr = '0; p1_if.wdata = '0;
      for (int i = 0; i < 64; i++) m_mem[i] = '0;
      m_rd[0] = '0; m_rd[1] = '0; m_last = 1;

      tbl[0] = '{1, 1, 6'h05, 32'h8000_1111, 0, 0, 6'h00, 32'h0, 2, -1, 1, 6'h05, 32'h8000_1111, 32'h0, 32'h0};
      tbl[1] = '{1, 0, 6'h05, 32'h0, 0, 0, 6'h00, 32'h0, 3, -1, -1, 6'h00, 32'h0, 32'h8000_1111, 32'h0};
      tbl[2] = '{0, 0, 6'h00, 32'h0, 1, 1, 6'h01, 32'h1000_0001, -1, 2, 1, 6'h01, 32'h1000_0001, 32'h8000_1111, 32'h0};
      tbl[3] = '{1, 0, 6'h05, 32'h0, 1, 0, 6'h01, 32'h0, 3, 7, -1, 6'h00, 32'h0, 32'h8000_1111, 32'h1000_0001};
      tbl[4] = '{1, 1, 6'h0A, 32'hAAAA_000A, 1, 1, 6'h0B, 32'hBBBB_000B, 2, 5, 1, 6'h0A, 32'hAAAA_000A, 32'h8000_1111, 32'h1000_0001};
      tbl[5] = '{1, 0, 6'h0B, 32'h0, 1, 0, 6'h0A, 32'h0, 3, 7, -1, 6'h00, 32'h0, 32'hBBBB_000B, 32'hAAAA_000A};
      tbl[6] = '{1, 1, 6'h0C, 32'hCCCC_000C, 0, 0, 6'h00, 32'h0, 2, -1, 1, 6'h0C, 32'hCCCC_000C, 32'hBBBB_000B, 32'hAAAA_000A};
`ifdef MEM_ARB_FIXED_PRIO_EN
      tbl[7] = '{1, 0, 6'h0C, 32'h0, 1, 0, 6'h0C, 32'h0, 3, 7, -1, 6'h00, 32'h0, 32'hCCCC_000C, 32'hCCCC_000C};
`else
      tbl[7] = '{1, 0, 6'h0C, 32'h0, 1, 0, 6'h0C, 32'h0, 7, 3, -1, 6'h00, 32'h0, 32'hCCCC_000C, 32'hCCCC_000C};
`endif

      rst = 1'b1;
      #12;
      chk("reset ack0", p0_if.ack, 0);
      chk("reset ack1", p1_if.ack, 0);
      chk("reset rdata0", p0_if.rdata, 0);
      chk("reset rdata1", p1_if.rdata, 0);
      chk("reset ram_we", ram_we, 0);
      chk("reset ram_addr", ram_addr, 0);
      chk("reset ram_din", ram_din, 0);
      chk("reset busy", busy, 0);
      @(posedge clk); #1;
      rst = 1'b0;

      for (int i = 0; i < 8; i++) apply_and_check($sformatf("vec%0d", i), tbl[i], 1'b0);

      for (int i = 0; i < 40; i++) begin
         v.en0 = 1'($urandom_range(0, 1)); v.en1 = 1'($urandom_range(0, 1));
         if (!v.en0 && !v.en1) v.en0 = 1'b1;
         v.we0 = 1'($urandom_range(0, 1)); v.we1 = 1'($urandom_range(0, 1));
         v.a0 = 6'($urandom_range(16, 31)); v.a1 = 6'($urandom_range(16, 31));
         v.d0 = $urandom; v.d1 = $urandom;
         apply_and_check($sformatf("rnd%0d", i), v, 1'b1);
      end

      alt_seq();

      // Abort a port 1 read in CAPTURE; rdata1 is loaded first so the clear is visible.
      v = '{0, 0, 6'h00, 32'h0, 1, 0, 6'h01, 32'h0, -1, 2, -1, 6'h00, 32'h0, 32'h0, 32'h0};
      apply_and_check("pre-abort read", v, 1'b1);
      chk("pre-abort rdata1", p1_if.rdata, 32'h1000_0001);
      @(posedge clk); #1;
      p1_if.req = 1'b1; p1_if.we = 1'b0; p1_if.addr = 6'h01;
      @(negedge clk); @(negedge clk); @(negedge clk);
      chk("abort busy before rst", busy, 1);
      rst = 1'b1;
      #1;
      chk("abort ram_we", ram_we, 0);
      chk("abort ack1", p1_if.ack, 0);
      chk("abort rdata1", p1_if.rdata, 0);
      chk("abort busy", busy, 0);
      chk("abort ram_addr", ram_addr, 0);
      p1_if.req = 1'b0;
      m_rd[0] = '0; m_rd[1] = '0; m_last = 1;
      @(posedge clk); #1;
      rst = 1'b0;
      acks = 0; busy_hi = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (p0_if.ack || p1_if.ack) acks++;
         if (busy) busy_hi++;
      end
      chk("post-abort acks", acks, 0);
      chk("post-abort busy", busy_hi, 0);
      chk("post-abort rdata1", p1_if.rdata, 0);

      v = '{1, 0, 6'h05, 32'h0, 1, 0, 6'h01, 32'h0, 3, 7, -1, 6'h00, 32'h0, 32'h8000_1111, 32'h1000_0001};
      apply_and_check("post-reset tie", v, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
endmodule

// File: doc/mem_arb2p.md
Name: mem_arb2p

Overview:
- Two-port arbiter and sequencer for the single-port 64x32 synchronous data RAM (RAM_B IP: 1-cycle read latency, write on wea).
- Lets two requesters share one RAM: port 0 is the CPU data path, port 1 is the switch/LED debug panel.
- Arbitrates between them, serialises accesses, drives the RAM pins, and returns a per-port ack and read data.
- Instantiated next to RAM_B; all RAM pins are driven only by this block.

Parameters:
- ADDR_W, 6, word-address width (addresses bits [7:2] of the byte address).
- DATA_W, 32, data word width.

Ports:
- Clk  input  1  system clock, rising edge.
- Rst  input  1  reset; asynchronous, active-high.
- req0  input  1  port 0 request; held high with we0/addr0/wdata0 stable until ack0.
- we0  input  1  port 0 access type: 1 = write, 0 = read.
- addr0  input  ADDR_W  port 0 word address.
- wdata0  input  DATA_W  port 0 write data.
- ack0  output  1  port 0 completion, one-cycle pulse.
- rdata0  output  DATA_W  port 0 read data; valid from the cycle of ack0 until the next port 0 read completes.
- req1, we1, addr1, wdata1, ack1, rdata1: same as port 0, for port 1.
- ram_we  output  1  to RAM wea.
- ram_addr  output  ADDR_W  to RAM addra.
- ram_din  output  DATA_W  to RAM dina.
- ram_dout  input  DATA_W  from RAM douta.
- busy  output  1  high whenever the state is not IDLE.

Behaviour:
- Reset: the following clear immediately on Rst.
  - State goes to IDLE.
  - ram_we=0, ram_addr=0, ram_din=0.
  - ack0=ack1=0, rdata0=rdata1=0, busy=0.
  - Round-robin pointer set so that port 0 wins the first tie.
- All outputs are registered.
- FSM states: IDLE, ISSUE, CAPTURE, ACK.
- IDLE:
  - Samples req0/req1.
  - If only one is high, that port is granted.
  - If both are high, the port not granted last time wins.
  - On grant, the winner's we/addr/wdata are latched into ram_we/ram_addr/ram_din, owner is recorded, and the next state is ISSUE.
  - If neither is high, stay in IDLE with ram_we=0.
- ISSUE: lasts one cycle. The RAM captures at the closing edge.
  - Next state is CAPTURE for a read, ACK for a write.
  - ram_we returns to 0 on exit, so ram_we is high for exactly one cycle per write.
- CAPTURE (read only): ram_dout is valid this cycle. It is registered into rdata of the owner at the closing edge. Next state is ACK.
- ACK: ack of the owner is high for exactly this cycle. Next state is IDLE.
- Latency from the req-sampled cycle (c0) in IDLE:
  - Write: ack in c2.
  - Read: ack in c3, rdata valid in c3.
  - Back-to-back throughput: one write per 3 cycles, one read per 4 cycles.
- Requester protocol:
  - req must be low in the cycle after ack.
  - A req still high when IDLE samples it is a new access.
- The non-owner port's req, inputs and rdata are unaffected while the other port is being served. Its req waits with no timeout.
- The round-robin pointer updates on every grant, including uncontested ones.
- ram_addr and ram_din hold their last value while IDLE.
- Read of a never-written address returns whatever the RAM holds; no checking is done.
- Rst mid-operation:
  - The access is aborted and no ack is issued.
  - rdata is cleared.
  - A write aborted in ISSUE has ram_we forced low immediately; whether it landed is undefined.
- The arbiter does not detect same-address or read-after-write hazards. Ordering is strictly grant order.

Optional Feature:
- Macro: MEM_ARB_FIXED_PRIO_EN.
- Defined: on a tie, port 0 always wins. The round-robin pointer is removed, and port 1 can starve under continuous port 0 traffic.
- Undefined: round-robin tie-break as described under Behaviour.

Test Plan:
- Reset, then port 0 write addr 6'h05, data 32'h8000_1111 at c0:
  - ram_we=1 only in c1, with ram_addr=05 and ram_din=8000_1111.
  - ack0 pulses in c2.
  - ack1 stays 0.
- Following write case: port 0 read addr 6'h05 at c0 -> ack0 in c3 and rdata0=32'h8000_1111, held after ack.
- Port 1 pre-writes 6'h01=32'h1000_0001, then req0 and req1 both rise (reads of 05 and 01) in the same cycle c0:
  - Port 0 is served first, with ack0 in c3.
  - Port 1 is granted in c4, with ack1 in c7 and rdata1=32'h1000_0001.
- Both ports re-request immediately after every ack for 8 accesses -> grants alternate 0,1,0,1,..., with no ack overlap and busy low only in IDLE cycles.
- Rst asserted during CAPTURE of a port 1 read:
  - ram_we=0, ack1=0, rdata1=0, busy=0 asynchronously.
  - After release with no req: no ack is ever produced and the state stays IDLE.
- With MEM_ARB_FIXED_PRIO_EN defined, continuous req0 and req1 -> every grant goes to port 0 and ack1 never pulses. Dropping req0 -> port 1 is acked in the expected 3 or 4 cycles.
